multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have port instr, input, 32 bits: instruction word from instruction memory, sampled only in FETCH when mem_ready=1.
REQ-004 The block SHALL have port mem_ready, input, 1 bit: memory handshake completion for the current fetch, load or store.
REQ-005 The block SHALL have port br_taken, input, 1 bit: ALU branch-condition result, sampled in EXEC.
REQ-006 The block SHALL have port imm_type, output, 2 bits: select for the immediate generator; 01 I, 10 S, 11 B, 00 none/R-type.
REQ-007 The block SHALL have ports mem_read, mem_write, ir_write, pc_write, pc_src, alu_src and reg_write, each an output of 1 bit: datapath strobes.
REQ-008 The block SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-009 The block SHALL have ports illegal and timeout, each an output of 1 bit: sticky trap causes.
REQ-010 The block SHALL have port retire_cnt, output, 16 bits: count of retired instructions.

Function
REQ-011 The FSM SHALL use the encodings FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6 and 7 SHALL go to TRAP with illegal=1.
REQ-012 In FETCH, mem_read=1 until mem_ready=1; on that cycle ir_write=1, pc_write=1, pc_src=0 (PC+4), instr[6:0] is latched to an internal opcode, and the next state is DECODE.
REQ-013 In DECODE, imm_type SHALL be registered from the latched opcode: 0010011 and 0000011 give 01, 0100011 gives 10, 1100011 gives 11, and 0110011 gives 00.
REQ-014 In DECODE, any other opcode SHALL go to TRAP and set illegal=1; otherwise the next state is EXEC.
REQ-015 imm_type SHALL remain stable from EXEC until the next DECODE.
REQ-016 In EXEC: alu_src=1 for I-ALU, load and store, and 0 for R-type and branch; R-type and I-ALU go to WB; load and store go to MEM.
REQ-017 In EXEC for a branch: if br_taken=1 then pc_write=1 and pc_src=1 for exactly one cycle; the next state is FETCH either way.
REQ-018 In MEM, the FSM SHALL hold mem_read (load) or mem_write (store) high until mem_ready=1; a load then goes to WB and a store goes to FETCH.
REQ-019 In WB, reg_write=1 for exactly one cycle; the next state is FETCH.
REQ-020 retire_cnt SHALL increment by 1 on each transition into FETCH from EXEC, MEM or WB, and SHALL wrap from FFFF to 0000.
REQ-021 TRAP SHALL be absorbing: all strobes 0, illegal/timeout held, and exit only by rst.
REQ-022 mem_ready outside FETCH/MEM SHALL be ignored; mem_read and mem_write SHALL never both be 1.
REQ-023 All strobes SHALL be 0 in any state or cycle not listed above.

Reset
REQ-024 While rst=1, regardless of clk and including mid-transaction: state=FETCH, all strobes 0, imm_type=00, illegal=0, timeout=0, retire_cnt=0, and the internal opcode and timeout counter are cleared.
REQ-025 In the first cycle after rst deasserts, the block SHALL be in FETCH with mem_read=1.

Configuration
REQ-026 With macro MULTICYCLE_CTRL_TIMEOUT_EN defined, a 4-bit wait counter SHALL count cycles in FETCH/MEM with mem_ready=0; at count 15 with mem_ready still 0, the next state is TRAP and timeout=1; the counter SHALL clear on mem_ready or on a state change.
REQ-027 Without MULTICYCLE_CTRL_TIMEOUT_EN, FETCH/MEM SHALL wait indefinitely and timeout SHALL be tied to 0.

Verification
REQ-028 Reset, then feed instr=0x00A00093 (addi) with mem_ready=1 -> sequence FETCH, DECODE, EXEC, WB, FETCH; imm_type=01; alu_src=1 in EXEC; one reg_write pulse; retire_cnt=1.
REQ-029 Feed instr=0x00112223 (sw) with mem_ready delayed 3 cycles in MEM -> imm_type=10; mem_write high for exactly 4 cycles; no reg_write; FETCH follows.
REQ-030 Feed instr=0x00208463 (beq) with br_taken=1, then again with br_taken=0 -> imm_type=11; pc_src=1 and pc_write=1 in EXEC only when taken; retire_cnt=2.
REQ-031 Feed instr=0xFFFFFFFF -> TRAP, illegal=1, state=5 held for 20 cycles; rst -> FETCH with illegal=0.
REQ-032 Assert rst during MEM of a load -> mem_read drops asynchronously; state=0 and retire_cnt=0 after release.
REQ-033 With MULTICYCLE_CTRL_TIMEOUT_EN defined and mem_ready held 0 in FETCH -> TRAP with timeout=1 after 16 cycles; with the macro undefined -> remains in FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Purpose: multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) driving datapath strobes for a small RISC-V subset.
// Latency: one state per cycle; the strobes are combinational from the state; imm_type, illegal, timeout and retire_cnt are registered.
// Backpressure: FETCH and MEM stall on mem_ready=0. The optional MULTICYCLE_CTRL_TIMEOUT_EN watchdog traps after 16 stalled cycles.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic [1:0]  imm_type,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        illegal,
    output logic        timeout,
    output logic [15:0] retire_cnt
);

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;

    localparam logic [1:0] IMM_NONE = 2'b00;
    localparam logic [1:0] IMM_I    = 2'b01;
    localparam logic [1:0] IMM_S    = 2'b10;
    localparam logic [1:0] IMM_B    = 2'b11;

    state_e      state_q, state_d;
    logic [6:0]  opcode_q, opcode_d;
    logic [1:0]  imm_type_q, imm_type_d;
    logic        illegal_q, illegal_d;
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic        wait_hit;

    // Raw strobes before the reset gate.
    logic mem_read_c, mem_write_c, ir_write_c, pc_write_c;
    logic pc_src_c, alu_src_c, reg_write_c;

    // Only the opcode field of the instruction word is decoded here.
    logic unused_instr;
    assign unused_instr = ^instr[31:7];

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
    logic       mem_wait;

    // Watchdog: count stalled FETCH/MEM cycles. The count clears when mem_ready is seen or the state changes.
    always_comb begin
        mem_wait   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
        wait_hit   = mem_wait && (wait_cnt_q == 4'd15);
        wait_cnt_d = 4'd0;
        if (mem_wait && !wait_hit) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
        timeout_d  = timeout_q | wait_hit;
    end

    // Watchdog registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    // Without the watchdog, FETCH and MEM wait forever.
    assign wait_hit = 1'b0;
    assign timeout  = 1'b0;
`endif

    // Next-state, decode and strobe generation.
    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        imm_type_d   = imm_type_q;
        illegal_d    = illegal_q;
        retire_cnt_d = retire_cnt_q;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        alu_src_c    = 1'b0;
        reg_write_c  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;    // pc_src stays 0: PC+4
                    opcode_d   = instr[6:0];
                    state_d    = ST_DECODE;
                end else if (wait_hit) begin
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                state_d = ST_EXEC;
                case (opcode_q)
                    OP_IALU,
                    OP_LOAD:   imm_type_d = IMM_I;
                    OP_STORE:  imm_type_d = IMM_S;
                    OP_BRANCH: imm_type_d = IMM_B;
                    OP_RTYPE:  imm_type_d = IMM_NONE;
                    default: begin
                        imm_type_d = IMM_NONE;
                        illegal_d  = 1'b1;
                        state_d    = ST_TRAP;
                    end
                endcase
            end

            ST_EXEC: begin
                case (opcode_q)
                    OP_IALU: begin
                        alu_src_c = 1'b1;
                        state_d   = ST_WB;
                    end
                    OP_RTYPE: begin
                        state_d = ST_WB;
                    end
                    OP_LOAD,
                    OP_STORE: begin
                        alu_src_c = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OP_BRANCH: begin
                        pc_write_c   = br_taken;
                        pc_src_c     = br_taken;
                        state_d      = ST_FETCH;
                        retire_cnt_d = retire_cnt_q + 16'd1;
                    end
                    default: begin
                        // DECODE already filters bad opcodes. This arm is a safety net only.
                        illegal_d = 1'b1;
                        state_d   = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                // Only a load or a store can reach MEM, so exactly one of the two memory strobes is raised.
                if (opcode_q == OP_LOAD) begin
                    mem_read_c = 1'b1;
                end else begin
                    mem_write_c = 1'b1;
                end
                if (mem_ready) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        state_d      = ST_FETCH;
                        retire_cnt_d = retire_cnt_q + 16'd1;
                    end
                end else if (wait_hit) begin
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                reg_write_c  = 1'b1;
                state_d      = ST_FETCH;
                retire_cnt_d = retire_cnt_q + 16'd1;
            end

            ST_TRAP: begin
                state_d = ST_TRAP;
            end

            default: begin
                // Unused encodings 6 and 7.
                illegal_d = 1'b1;
                state_d   = ST_TRAP;
            end
        endcase
    end

    // State and architectural registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            opcode_q     <= 7'd0;
            imm_type_q   <= IMM_NONE;
            illegal_q    <= 1'b0;
            retire_cnt_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            imm_type_q   <= imm_type_d;
            illegal_q    <= illegal_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Strobes are forced low for the whole of reset, including in the FETCH state that reset selects.
    assign mem_read   = mem_read_c  & ~rst;
    assign mem_write  = mem_write_c & ~rst;
    assign ir_write   = ir_write_c  & ~rst;
    assign pc_write   = pc_write_c  & ~rst;
    assign pc_src     = pc_src_c    & ~rst;
    assign alu_src    = alu_src_c   & ~rst;
    assign reg_write  = reg_write_c & ~rst;

    assign imm_type   = imm_type_q;
    assign state      = state_q;
    assign illegal    = illegal_q;
    assign retire_cnt = retire_cnt_q;

endmodule
